// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Fetch-side program-counter controller for the RV32I core. Owns the fetch
// PC and walks it through BOOT -> RUN, with RUN handling redirects from the
// execute-stage next-PC selector, halts, stalls and sequential increment.
// HALT and TRAP are terminal until reset.
//
// Optional feature macro: PC_FETCH_STATS_EN
//   defined   -> saturating redirect/stall performance counters
//   undefined -> redirect_count/stall_count tied to 0, no counter flops
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall               hold the PC this cycle
//   ex_valid            execute stage holds a live instruction
//   redirect            taken-branch/jump flag (qualified by ex_valid)
//   redirect_target     resolved next PC
//   halt_req            ECALL/EBREAK seen in decode
//   pc, pc_plus4        fetch address and its sequential successor
//   if_valid            pc is a real fetch this cycle
//   flush_if, flush_id  clear IF/ID and ID/EX at the next edge
//   halted              core stopped by halt_req
//   misaligned          sticky misaligned-redirect flag
//   redirect_count      accepted redirects (stats build only)
//   stall_count         stalled RUN cycles (stats build only)
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             halt_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             if_valid,
    output logic             flush_if,
    output logic             flush_id,
    output logic             halted,
    output logic             misaligned,
    output logic [31:0]      redirect_count,
    output logic [31:0]      stall_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_TRAP = 2'd3
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic             if_valid_q;
    logic             halted_q;
    logic             misaligned_q;

    logic             redirect_take;
    logic             target_aligned;

    // A redirect is only acted on in RUN and only for a live EX instruction;
    // it outranks stall and halt_req because those belong to the wrong path.
    assign redirect_take  = (state_q == ST_RUN) && ex_valid && redirect;
    assign target_aligned = (redirect_target[1:0] == 2'b00);

    // Flushes are combinational so both pipeline registers clear on the same
    // edge that loads the target; a misaligned target also kills the
    // younger instructions on its way into TRAP.
    assign flush_if = redirect_take;
    assign flush_id = redirect_take;

    assign pc_plus4   = pc_q + WIDTH'(4);
    assign pc         = pc_q;
    assign if_valid   = if_valid_q;
    assign halted     = halted_q;
    assign misaligned = misaligned_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            if_valid_q   <= 1'b0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q    <= ST_RUN;
                    if_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    if (redirect_take && target_aligned) begin
                        pc_q <= redirect_target;
                    end else if (redirect_take) begin
                        state_q      <= ST_TRAP;
                        if_valid_q   <= 1'b0;
                        misaligned_q <= 1'b1;
                    end else if (halt_req) begin
                        state_q    <= ST_HALT;
                        if_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else if (!stall) begin
                        pc_q <= pc_plus4;
                    end
                end
                ST_HALT, ST_TRAP: begin
                    // Terminal: PC and flags frozen until reset.
                end
                default: begin
                    state_q    <= ST_BOOT;
                    if_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_FETCH_STATS_EN
    logic        redirect_accept;
    logic        stall_accept;
    logic [31:0] redirect_count_q;
    logic [31:0] stall_count_q;

    // Misaligned redirects count as accepted; a stall only counts when no
    // higher-priority event claimed the cycle.
    assign redirect_accept = redirect_take;
    assign stall_accept    = (state_q == ST_RUN) && !redirect_take && !halt_req && stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_count_q <= '0;
            stall_count_q    <= '0;
        end else begin
            if (redirect_accept && (redirect_count_q != 32'hFFFF_FFFF)) begin
                redirect_count_q <= redirect_count_q + 32'd1;
            end
            if (stall_accept && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign redirect_count = redirect_count_q;
    assign stall_count    = stall_count_q;
`else
    assign redirect_count = 32'd0;
    assign stall_count    = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Directed bench for pc_fetch_ctrl with RESET_PC = 0x100. Each vector is
// driven 1 ns after a rising edge; outputs are checked 1 ns after the edge
// (registered values) or 1 ns after the drive (combinational flushes).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;

`ifdef PC_FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_valid;
    logic        flush_if;
    logic        flush_id;
    logic        halted;
    logic        misaligned;
    logic [31:0] redirect_count;
    logic [31:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_ctrl #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_valid        (ex_valid),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .if_valid        (if_valid),
        .flush_if        (flush_if),
        .flush_id        (flush_id),
        .halted          (halted),
        .misaligned      (misaligned),
        .redirect_count  (redirect_count),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic exv, input logic rd,
                         input logic [31:0] tgt, input logic hr);
        stall           = st;
        ex_valid        = exv;
        redirect        = rd;
        redirect_target = tgt;
        halt_req        = hr;
    endtask

    function automatic logic [31:0] cnt(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        // Reset values
        check_eq("rst_pc",       pc,             32'h100);
        check_eq("rst_if_valid", {31'd0, if_valid},   32'd0);
        check_eq("rst_flush",    {30'd0, flush_if, flush_id}, 32'd0);
        check_eq("rst_halted",   {31'd0, halted},     32'd0);
        check_eq("rst_misal",    {31'd0, misaligned}, 32'd0);
        check_eq("rst_rcnt",     redirect_count, 32'd0);
        check_eq("rst_scnt",     stall_count,    32'd0);

        // Release between edges; the cycle up to the next edge is BOOT.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("boot_pc",       pc,                 32'h100);
        check_eq("boot_if_valid", {31'd0, if_valid},  32'd0);
        tick();
        check_eq("run0_pc",       pc,                 32'h100);
        check_eq("run0_if_valid", {31'd0, if_valid},  32'd1);
        check_eq("run0_plus4",    pc_plus4,           32'h104);
        tick(); check_eq("run1_pc", pc, 32'h104);
        tick(); check_eq("run2_pc", pc, 32'h108);
        tick(); check_eq("run3_pc", pc, 32'h10C);
        tick(); check_eq("run4_pc", pc, 32'h110);

        // Redirect with stall in the same cycle: redirect wins.
        drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
        #1;
        check_eq("redir_flush_if", {31'd0, flush_if}, 32'd1);
        check_eq("redir_flush_id", {31'd0, flush_id}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("redir_pc",   pc,             32'h40);
        check_eq("redir_rcnt", redirect_count, cnt(1));
        check_eq("redir_scnt", stall_count,    cnt(0));
        #1;
        check_eq("post_redir_flush", {31'd0, flush_if}, 32'd0);

        // Redirect to 0x20, then hold stall for 3 cycles.
        drive(1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
        tick();
        check_eq("to20_pc", pc, 32'h20);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check_eq("stall_noflush", {31'd0, flush_if}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("stall%0d_pc", i), pc, 32'h20);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check_eq("unstall_pc", pc,          32'h24);
        check_eq("stall_scnt", stall_count, cnt(3));

        // Redirect with ex_valid=0 is ignored.
        drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
        #1;
        check_eq("ign_flush_if", {31'd0, flush_if}, 32'd0);
        check_eq("ign_flush_id", {31'd0, flush_id}, 32'd0);
        tick();
        check_eq("ign_pc",   pc,             32'h28);
        check_eq("ign_rcnt", redirect_count, cnt(2));

        // Wrap at the top of the address space.
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("top_pc",    pc,       32'hFFFF_FFFC);
        check_eq("top_plus4", pc_plus4, 32'h0);
        tick();
        check_eq("wrap_pc",   pc,       32'h0);

        // halt_req with an aligned redirect: redirect taken, no halt.
        drive(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("hr_pc",       pc,                 32'h200);
        check_eq("hr_halted",   {31'd0, halted},    32'd0);
        check_eq("hr_if_valid", {31'd0, if_valid},  32'd1);
        check_eq("hr_rcnt",     redirect_count,     cnt(4));

        // halt_req alone: halt, then everything ignored.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check_eq("halt_halted",   {31'd0, halted},   32'd1);
        check_eq("halt_if_valid", {31'd0, if_valid}, 32'd0);
        check_eq("halt_pc",       pc,                32'h200);
        drive(1'b1, 1'b1, 1'b1, 32'h300, 1'b0);
        #1;
        check_eq("halt_flush", {30'd0, flush_if, flush_id}, 32'd0);
        for (int i = 0; i < 11; i++) begin
            drive(i[0], 1'b1, 1'b1, 32'h300 + 32'(i * 4), i[1]);
            tick();
        end
        check_eq("halt_frozen_pc", pc,               32'h200);
        check_eq("halt_still",     {31'd0, halted},  32'd1);
        check_eq("halt_rcnt",      redirect_count,   cnt(4));
        check_eq("halt_scnt",      stall_count,      cnt(3));

        // Asynchronous reset out of HALT, mid-cycle.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("arst_pc",     pc,              32'h100);
        check_eq("arst_halted", {31'd0, halted}, 32'd0);
        check_eq("arst_rcnt",   redirect_count,  32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("reboot_pc", pc, 32'h100);

        // Misaligned redirect target -> TRAP.
        drive(1'b0, 1'b1, 1'b1, 32'h42, 1'b0);
        #1;
        check_eq("mis_flush_if", {31'd0, flush_if}, 32'd1);
        check_eq("mis_flush_id", {31'd0, flush_id}, 32'd1);
        tick();
        check_eq("mis_flag",     {31'd0, misaligned}, 32'd1);
        check_eq("mis_if_valid", {31'd0, if_valid},   32'd0);
        check_eq("mis_pc",       pc,                  32'h100);
        check_eq("mis_rcnt",     redirect_count,      cnt(1));
        #1;
        check_eq("trap_flush", {30'd0, flush_if, flush_id}, 32'd0);
        tick(); tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("trap_sticky", {31'd0, misaligned}, 32'd1);
        check_eq("trap_pc",     pc,                  32'h100);

        // Reset clears TRAP back to BOOT.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("trap_rst_misal", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("trap_boot_ifv", {31'd0, if_valid}, 32'd0);
        tick(); tick();
        check_eq("trap_run_pc", pc, 32'h104);

        // Async reset pulse between edges during a redirect.
        drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midredir_pc",    pc,                32'h100);
        check_eq("midredir_flush", {31'd0, flush_if}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        rst = 1'b0;
        tick();
        check_eq("midredir_after_pc", pc, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
